// File: rtl/shift_div_seq.sv
// -----------------------------------------------------------------------------
// shift_div_seq
//   Multi-cycle power-of-two divider built on a right-shift datapath.
//   Divides a WIDTH-bit operand by 2^k (k given at runtime, clamped to WIDTH).
//   Logical mode divides unsigned. Arithmetic mode divides signed with floor
//   rounding. The result is a quotient and a non-negative remainder.
//   The datapath moves at most STEP bit positions per clock.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand presented
//   in_ready   block can accept an operand (registered)
//   data       dividend
//   shamt      shift distance k; values >= WIDTH clamp to WIDTH
//   arith      0 = logical (zero fill), 1 = arithmetic (sign fill, floor)
//   out_valid  result available
//   out_ready  consumer takes the result
//   q          quotient
//   rem        remainder, zero-extended
//   busy       high while an operation is in SHIFT or DONE
// -----------------------------------------------------------------------------
module shift_div_seq #(
  parameter int WIDTH = 8,
  parameter int STEP  = 2,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data,
  input  logic [SHW-1:0]   shamt,
  input  logic             arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rem,
  output logic             busy
);

  // The counter and the position must both hold values from 0 to WIDTH.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
  localparam logic [CW-1:0] STEP_C  = CW'(STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;      // shift positions still to apply
  logic [CW-1:0]    pos_q, pos_d;      // positions already shifted out
  logic [WIDTH-1:0] work_q, work_d;    // working register, becomes q
  logic [WIDTH-1:0] rem_q, rem_d;      // collected remainder bits
  logic             arith_q, arith_d;  // captured mode
  logic             in_ready_q, in_ready_d;

  logic             accept;
  logic [CW-1:0]    kc;                // clamped shift distance
  logic [CW-1:0]    step_sz;           // distance applied on this SHIFT edge
  logic [WIDTH-1:0] out_mask;          // selects the bits about to fall out

  // in_ready_q is only ever high in IDLE, so it alone qualifies acceptance.
  assign accept = in_valid && in_ready_q;

  always_comb begin
    if (32'(shamt) >= 32'(WIDTH)) kc = WIDTH_C;
    else                          kc = CW'(shamt);
  end

  assign step_sz  = (cnt_q < STEP_C) ? cnt_q : STEP_C;
  assign out_mask = ~({WIDTH{1'b1}} << step_sz);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so that every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output is given a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = (kc == '0) ? DONE : SHIFT;
      SHIFT: if (cnt_q <= STEP_C) state_d = DONE;
      DONE:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Registered ready: high on the edge that lands in IDLE. This covers the
    // retire edge, and the acceptance edge drops it again.
    in_ready_d = (state_d == IDLE);
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  assign in_ready = in_ready_q;
  assign q        = work_q;
  assign rem      = rem_q;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    work_d  = work_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    arith_d = arith_q;
    if (accept) begin
      work_d  = data;
      rem_d   = '0;
      cnt_d   = kc;
      pos_d   = '0;
      arith_d = arith;
    end else if (state_q == SHIFT) begin
      // In arithmetic mode the MSB of work_q is always the captured data MSB,
      // because every earlier step filled with that bit.
      if (arith_q) work_d = $signed(work_q) >>> step_sz;
      else         work_d = work_q >> step_sz;
      // The outgoing low bits go above those already collected, so the
      // remainder ends up equal to data[kc-1:0].
      rem_d = rem_q | ((work_q & out_mask) << pos_q);
      cnt_d = cnt_q - step_sz;
      pos_d = pos_q + step_sz;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      pos_q   <= '0;
      arith_q <= 1'b0;
    end else begin
      work_q  <= work_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      arith_q <= arith_d;
    end
  end

endmodule
